// File: rtl/full_adder.sv
// rtl/full_adder.sv - registered ripple-carry adder: {cout, sum} = a + b + cin, one-cycle latency
module full_adder #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             out_valid
);

  logic [WIDTH-1:0] sum_comb;
  logic             carry;

  // Ripple chain: the carry walks up from bit 0 seeded by cin.
  always_comb begin
    sum_comb = '0;
    carry    = cin;
    for (int i = 0; i < WIDTH; i++) begin
      sum_comb[i] = a[i] ^ b[i] ^ carry;
      carry       = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
  end

  // Result registers load only on valid so idle (possibly X) operands never reach the outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum       <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum  <= sum_comb;
        cout <= carry;
      end
    end
  end

endmodule

// File: tb/tb_full_adder.sv
// tb/tb_full_adder.sv - scoreboard bench for full_adder at WIDTH=1 and WIDTH=8
module tb_full_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [0:0] a1, b1;
  logic       c1, v1;
  logic [0:0] s1;
  logic       co1, ov1;
  logic [7:0] a8, b8;
  logic       c8, v8;
  logic [7:0] s8;
  logic       co8, ov8;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    bit         rst;
    bit         vld;
    logic [8:0] res;
  } exp_t;

  exp_t q1[$];
  exp_t q8[$];

  logic [8:0] h1 = '0, h8 = '0;
  bit         hv1 = 0, hv8 = 0;

  always #5 clk = ~clk;

  full_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .cin(c1), .in_valid(v1),
    .sum(s1), .cout(co1), .out_valid(ov1)
  );

  full_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .cin(c8), .in_valid(v8),
    .sum(s8), .cout(co8), .out_valid(ov8)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer addition; the held state tracks what the outputs must show.
  always @(negedge clk) begin
    exp_t e;
    if (q1.size() > 0) begin
      e = q1.pop_front();
      if (e.rst) begin h1 = '0; hv1 = 0; end
      else begin hv1 = e.vld; if (e.vld) h1 = e.res; end
      check("w1_out_valid", 64'(ov1), 64'(hv1));
      check("w1_sum",       64'(s1),  64'(h1[0]));
      check("w1_cout",      64'(co1), 64'(h1[1]));
    end
    if (q8.size() > 0) begin
      e = q8.pop_front();
      if (e.rst) begin h8 = '0; hv8 = 0; end
      else begin hv8 = e.vld; if (e.vld) h8 = e.res; end
      check("w8_out_valid", 64'(ov8), 64'(hv8));
      check("w8_sum",       64'(s8),  64'(h8[7:0]));
      check("w8_cout",      64'(co8), 64'(h8[8]));
    end
  end

  task automatic step();
    exp_t e1, e8;
    @(posedge clk);
    e1.rst = !rst_n; e1.vld = v1; e1.res = 9'(a1) + 9'(b1) + 9'(c1);
    e8.rst = !rst_n; e8.vld = v8; e8.res = 9'(a8) + 9'(b8) + 9'(c8);
    q1.push_back(e1);
    q8.push_back(e8);
    #1;
  endtask

  task automatic rand8(input bit vld);
    v8 = vld; a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
  endtask

  initial begin
    rst_n = 1'b0;
    v1 = 1'b1; a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
    rand8(1);
    #1;
    step();
    step();
    rst_n = 1'b1;

    // Exhaustive 1-bit truth table alongside random 8-bit traffic.
    for (int k = 0; k < 8; k++) begin
      v1 = 1'b1; a1 = 1'(k >> 2); b1 = 1'(k >> 1); c1 = 1'(k);
      rand8(1);
      step();
    end

    // Hold: one valid 1+1+1, then idle cycles with zero / unknown operands.
    v1 = 1'b1; a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
    v8 = 1'b1; a8 = 8'hA5; b8 = 8'h5A; c8 = 1'b1;
    step();
    for (int k = 0; k < 3; k++) begin
      v1 = 1'b0; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
      v8 = 1'b0; a8 = 'x; b8 = 'x; c8 = 1'bx;
      step();
    end

    // Reset wins over a simultaneous valid operand set.
    rst_n = 1'b0;
    v1 = 1'b1; a1 = 1'b1; b1 = 1'b0; c1 = 1'b1;
    v8 = 1'b1; a8 = 8'h01; b8 = 8'h00; c8 = 1'b1;
    step();
    rst_n = 1'b1;

    // Carry-chain and all-zero boundaries.
    v1 = 1'b1; a1 = 1'b1; b1 = 1'b0; c1 = 1'b1;
    v8 = 1'b1; a8 = 8'hFF; b8 = 8'h00; c8 = 1'b1;
    step();
    a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
    a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
    step();
    a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
    a8 = 8'h00; b8 = 8'h00; c8 = 1'b0;
    step();

    // Back-to-back streaming with a one-cycle reset pulse in the middle.
    for (int k = 0; k < 100; k++) begin
      rst_n = (k != 50);
      v1 = 1'b1; a1 = 1'($urandom); b1 = 1'($urandom); c1 = 1'($urandom);
      rand8(1);
      step();
    end
    rst_n = 1'b1;

    // Random valid gaps.
    for (int k = 0; k < 100; k++) begin
      v1 = 1'($urandom); a1 = 1'($urandom); b1 = 1'($urandom); c1 = 1'($urandom);
      rand8(1'($urandom));
      step();
    end

    v1 = 1'b0; v8 = 1'b0;
    step();
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
